// File: rtl/trap_arbiter.sv
// -----------------------------------------------------------------------------
// trap_arbiter
//
// Central trap scheduler for the Hunter_RV32 core. Picks one trap per idle
// cycle between synchronous exceptions (ebreak, ecall) and asynchronous
// interrupts (external, timer), redirects the PC to the handler vector,
// records the return PC and cause, tracks the in-handler window until mret,
// and then redirects back to the saved PC.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   ecall, ebreak   exception decoded at pc this cycle
//   timer_irq       timer interrupt request (level)
//   ext_irq         external interrupt request (level)
//   mie             global interrupt enable
//   mret            mret decoded this cycle
//   pc              PC of the instruction currently in decode
//   redirect        one-cycle pulse: PC mux selects redirect_pc
//   redirect_pc     redirect target (0 when redirect is low)
//   flush           same as redirect; kills younger instructions
//   mepc, mcause    saved return PC and cause of the last trap taken
//   in_handler      high from the handler redirect through the return redirect
//   double_fault    one-cycle pulse: an exception was dropped inside a handler
//   wdt_fault       one-cycle pulse: handler watchdog expiry
//
// Optional feature (macro TRAP_WATCHDOG_EN): a handler watchdog that forces a
// normal return after WDT_CYCLES handler cycles without mret. Without the
// macro the handler waits indefinitely and wdt_fault is tied low.
//
// Every output is either a flop or a decode of the state register, so there
// is no combinational path from any input to any output.
//
// The FSM state is held in the signal 'state' (type state_t) so that
// checkers can bind to it directly.
// -----------------------------------------------------------------------------
module trap_arbiter #(
    parameter logic [31:0] ECALL_VEC  = 32'h20,
    parameter logic [31:0] EBREAK_VEC = 32'h30,
    parameter logic [31:0] TIMER_VEC  = 32'h40,
    parameter logic [31:0] EXT_VEC    = 32'h50,
    parameter int          WDT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        timer_irq,
    input  logic        ext_irq,
    input  logic        mie,
    input  logic        mret,
    input  logic [31:0] pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic        in_handler,
    output logic        double_fault,
    output logic        wdt_fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        HANDLER  = 2'd2,
        RETURN   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        tmr_pend;
    logic        ext_pend;
    logic [31:0] vec_q;        // handler vector of the trap being entered

    logic        take_ebreak;
    logic        take_ecall;
    logic        take_ext;
    logic        take_tmr;
    logic        take_any;
    logic [31:0] trap_cause;
    logic [31:0] trap_vec;
    logic        wdt_expire;

    // ------------------------------------------------------------------
    // Trap selection: only evaluated in IDLE. Interrupts are taken from
    // the pending bits, never straight from the request lines.
    // ------------------------------------------------------------------
    always_comb begin
        take_ebreak = 1'b0;
        take_ecall  = 1'b0;
        take_ext    = 1'b0;
        take_tmr    = 1'b0;
        if (state == IDLE) begin
            if (ebreak)                 take_ebreak = 1'b1;
            else if (ecall)             take_ecall  = 1'b1;
            else if (ext_pend && mie)   take_ext    = 1'b1;
            else if (tmr_pend && mie)   take_tmr    = 1'b1;
        end
    end

    assign take_any = take_ebreak | take_ecall | take_ext | take_tmr;

    always_comb begin
        trap_cause = 32'h0;
        trap_vec   = 32'h0;
        if (take_ebreak) begin
            trap_cause = 32'h0000_0003;
            trap_vec   = EBREAK_VEC;
        end else if (take_ecall) begin
            trap_cause = 32'h0000_000B;
            trap_vec   = ECALL_VEC;
        end else if (take_ext) begin
            trap_cause = 32'h8000_000B;
            trap_vec   = EXT_VEC;
        end else if (take_tmr) begin
            trap_cause = 32'h8000_0007;
            trap_vec   = TIMER_VEC;
        end
    end

    // ------------------------------------------------------------------
    // Optional handler watchdog
    // ------------------------------------------------------------------
`ifdef TRAP_WATCHDOG_EN
    localparam int WDT_W = ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_fault_q;

    // The counter holds the number of HANDLER cycles already completed, so
    // the last allowed cycle is the one where it reads WDT_CYCLES-1. A
    // coincident mret takes priority over the expiry.
    assign wdt_expire = (state == HANDLER) && !mret &&
                        (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt     <= '0;
            wdt_fault_q <= 1'b0;
        end else begin
            wdt_fault_q <= wdt_expire;
            if (state == REDIRECT)
                wdt_cnt <= '0;
            else if (state == HANDLER)
                wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_fault = wdt_fault_q;
`else
    assign wdt_expire = 1'b0;
    assign wdt_fault  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (take_any) state_nxt = REDIRECT;
            REDIRECT: state_nxt = HANDLER;
            HANDLER:  if (mret || wdt_expire) state_nxt = RETURN;
            RETURN:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Pending bits: set on request, cleared when taken (clear wins; a
    // request still high re-sets the bit on the following edge).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_pend <= 1'b0;
            ext_pend <= 1'b0;
        end else begin
            tmr_pend <= (tmr_pend | timer_irq) & ~take_tmr;
            ext_pend <= (ext_pend | ext_irq)   & ~take_ext;
        end
    end

    // ------------------------------------------------------------------
    // Trap context and fault pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc         <= 32'h0;
            mcause       <= 32'h0;
            vec_q        <= 32'h0;
            double_fault <= 1'b0;
        end else begin
            if (take_any) begin
                mepc   <= pc;
                mcause <= trap_cause;
                vec_q  <= trap_vec;
            end
            // Exceptions in the flushed REDIRECT/RETURN slots are not faults.
            double_fault <= (state == HANDLER) && (ecall || ebreak);
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        redirect_pc = 32'h0;
        case (state)
            REDIRECT: redirect_pc = vec_q;
            RETURN:   redirect_pc = mepc;
            default:  redirect_pc = 32'h0;
        endcase
    end

    assign redirect   = (state == REDIRECT) || (state == RETURN);
    assign flush      = redirect;
    assign in_handler = (state != IDLE);

endmodule
